dds_pwm_dac: RTL and testbench
==============================

Name: dds_pwm_dac

Overview:
Downstream stage of the DDS sine generator. It consumes the 8-bit two's-complement samples the DDS produces and drives a single-bit PWM output whose duty cycle tracks each sample. Samples enter through a valid/ready handshake into a one-entry holding register. A new sample is committed only at PWM period boundaries, and the block flags underrun when no sample is waiting at a boundary.

Parameters:
DW, 8, sample width in bits; the PWM period is 2^DW ticks.
PRESCALE, 1, clocks per PWM tick (must be >= 1); the PWM period is PRESCALE*2^DW clocks.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  run enable for prescaler, counter and output
in_data  input  DW  sample, two's complement (-2^(DW-1) .. 2^(DW-1)-1)
in_valid  input  1  in_data valid
in_ready  output  1  holding register empty, sample will be accepted
pwm_out  output  1  registered PWM output
period_start  output  1  one-cycle pulse, first cycle of each new period
duty  output  DW  currently applied duty (offset binary)
underrun  output  1  sticky, boundary reached with no held sample
underrun_clr  input  1  synchronous clear of underrun

Behaviour:
- Reset values: ps_cnt=0, cnt=0, duty=2^(DW-1) (0x80, zero sample), hold_valid=0, hold_data=0, pwm_out=0, period_start=0, underrun=0.
- Reset asserted mid-operation clears everything immediately. A held sample is discarded.
- Offset conversion: duty value = in_data with MSB inverted. -128 maps to 0x00, 0 to 0x80, 127 to 0xFF.
- Handshake:
  - in_ready = !hold_valid (combinational; 1 out of reset).
  - Accept when in_valid & in_ready. On accept: hold_data <= converted in_data, hold_valid <= 1.
  - in_data is ignored when not accepted. The producer must hold in_data while in_valid && !in_ready.
- Tick:
  - ps_cnt counts 0..PRESCALE-1 while en=1, then wraps.
  - tick = en && (ps_cnt == PRESCALE-1). With PRESCALE=1, tick = en.
- Counter: on tick, cnt <= cnt+1, wrapping from 2^DW-1 to 0.
- Boundary = tick && cnt == 2^DW-1. On the boundary edge:
  - If hold_valid: duty <= hold_data and hold_valid <= 0. in_ready rises on the next cycle; a same-cycle accept is not possible.
  - Else: duty is unchanged and underrun <= 1.
  - period_start <= 1 for exactly one clock. It is 0 otherwise.
- PWM output:
  - pwm_out <= en && (cnt < duty), giving a fixed one-clock latency from cnt.
  - High time per period = duty*PRESCALE clocks. duty=0 gives a constantly low output; duty=0xFF gives 255 of 256 ticks high.
- en=0:
  - ps_cnt and cnt hold.
  - pwm_out goes 0 on the next edge.
  - No boundary, no underrun, no period_start.
  - The handshake stays active, so the holding register can still fill.
- underrun:
  - Set by an empty boundary; cleared by underrun_clr.
  - If set and clear occur in the same cycle, set wins.
- Samples never update duty mid-period, so the output is glitch-free.

Test Plan:
1. Reset, en=1, DW=8, PRESCALE=1, in_valid=0 -> pwm_out high 128 of every 256 clocks. At the first boundary (cnt=255 tick), period_start pulses, underrun=1 and duty stays 0x80.
2. Push in_data=0x80 (-128), then at the next boundary push 0x7F -> duty=0x00, pwm_out low for the whole period. The following period has duty=0xFF and 255 high clocks. underrun stays 0 once cleared.
3. Back-to-back handshake: in_valid held with 0x10 then 0x20 -> 0x10 is accepted in 1 cycle and in_ready=0 until the boundary. 0x20 is accepted the cycle after the boundary. Duty sequence is 0x90 then 0xA0.
4. PRESCALE=4 instance, sample 0x00 -> period 1024 clocks, pwm_out high 512 clocks, period_start every 1024 clocks.
5. Drop en at cnt=100 for 20 clocks -> cnt holds at 100, pwm_out=0 one cycle after en falls. Raise en -> counting resumes from 100 and the boundary is delayed by exactly 20 clocks.
6. underrun_clr asserted on the same cycle as an empty boundary -> underrun stays 1. Assert rst mid-period with hold_valid=1 -> in_ready=1, duty=0x80, pwm_out=0, cnt=0 immediately.

Source files
------------

// File: rtl/dds_pwm_dac.sv
// dds_pwm_dac: PWM DAC stage behind the DDS sine generator.
//
// Accepts signed DW-bit samples through a valid/ready handshake into a
// one-entry holding register. The held sample is converted to offset binary
// and becomes the applied duty only at a PWM period boundary, so the output
// never changes duty mid-period. A boundary with nothing held leaves the duty
// unchanged and raises a sticky underrun flag.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   en           run enable for prescaler, counter and PWM output
//   in_data      signed sample, two's complement
//   in_valid     in_data valid
//   in_ready     holding register empty (combinational)
//   pwm_out      registered PWM output
//   period_start one-cycle pulse on the first cycle of each period
//   duty         currently applied duty, offset binary
//   underrun     sticky flag: boundary reached with no held sample
//   underrun_clr synchronous clear of underrun (a same-cycle set wins)
module dds_pwm_dac #(
  parameter int DW       = 8,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          pwm_out,
  output logic          period_start,
  output logic [DW-1:0] duty,
  output logic          underrun,
  input  logic          underrun_clr
);

  localparam int            PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [PSW-1:0] PS_ZERO = PSW'(0);
  localparam logic [PSW-1:0] PS_ONE  = PSW'(1);
  localparam logic [DW-1:0]  CNT_LAST = {DW{1'b1}};
  localparam logic [DW-1:0]  CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]  CNT_ONE  = DW'(1);
  localparam logic [DW-1:0]  DUTY_MID = {1'b1, {(DW-1){1'b0}}};

  // Two's complement to offset binary: flipping the sign bit maps the most
  // negative sample to 0 and the most positive to all-ones.
  function automatic logic [DW-1:0] to_offset(input logic [DW-1:0] s);
    return {~s[DW-1], s[DW-2:0]};
  endfunction

  logic [PSW-1:0] r_ps_cnt;
  logic [DW-1:0]  r_cnt;
  logic [DW-1:0]  r_duty;
  logic [DW-1:0]  r_hold_data;
  logic           r_hold_valid;
  logic           r_pwm;
  logic           r_period_start;
  logic           r_underrun;

  logic w_tick;
  logic w_boundary;
  logic w_accept;

  assign w_tick     = en && (r_ps_cnt == PS_LAST);
  assign w_boundary = w_tick && (r_cnt == CNT_LAST);
  // Accept and boundary-commit are mutually exclusive: one needs the holding
  // register empty, the other needs it full.
  assign w_accept   = in_valid && !r_hold_valid;

  assign in_ready     = !r_hold_valid;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign duty         = r_duty;
  assign underrun     = r_underrun;

  // Prescaler: divides the enabled clock down to PWM ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps_cnt <= PS_ZERO;
    end else if (en) begin
      if (r_ps_cnt == PS_LAST) begin
        r_ps_cnt <= PS_ZERO;
      end else begin
        r_ps_cnt <= r_ps_cnt + PS_ONE;
      end
    end
  end

  // Period counter: advances once per tick and wraps naturally at 2^DW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_ZERO;
    end else if (w_tick) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Holding register and duty commit at period boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= CNT_ZERO;
      r_duty       <= DUTY_MID;
    end else if (w_boundary && r_hold_valid) begin
      r_duty       <= r_hold_data;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_data  <= to_offset(in_data);
      r_hold_valid <= 1'b1;
    end
  end

  // Sticky underrun: an empty boundary takes priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
    end else if (w_boundary && !r_hold_valid) begin
      r_underrun <= 1'b1;
    end else if (underrun_clr) begin
      r_underrun <= 1'b0;
    end
  end

  // Registered PWM compare and period-start pulse (one clock behind cnt).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= en && (r_cnt < r_duty);
      r_period_start <= w_boundary;
    end
  end

endmodule

// File: tb/tb_dds_pwm_dac.sv
// tb_dds_pwm_dac: directed self-checking bench for dds_pwm_dac.
// u1 is the DW=8, PRESCALE=1 instance; u4 is the PRESCALE=4 instance.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_dds_pwm_dac;

  logic       clk = 1'b0;
  logic       rst;
  logic       underrun_clr;

  logic       en1, valid1, ready1, pwm1, ps1, ur1;
  logic [7:0] data1, duty1;
  logic       en4, valid4, ready4, pwm4, ps4, ur4;
  logic [7:0] data4, duty4;
  logic       clr4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dds_pwm_dac #(.DW(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .in_data(data1), .in_valid(valid1),
    .in_ready(ready1), .pwm_out(pwm1), .period_start(ps1), .duty(duty1),
    .underrun(ur1), .underrun_clr(underrun_clr)
  );

  dds_pwm_dac #(.DW(8), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .en(en4), .in_data(data4), .in_valid(valid4),
    .in_ready(ready4), .pwm_out(pwm4), .period_start(ps4), .duty(duty4),
    .underrun(ur4), .underrun_clr(clr4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance n clocks; count pwm high samples and period_start pulses.
  task automatic run(input bit sel4, input int n, output int highs,
                     output int starts, output int first);
    highs = 0; starts = 0; first = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (sel4 ? pwm4 : pwm1) highs++;
      if (sel4 ? ps4 : ps1) begin
        starts++;
        if (first == 0) first = k;
      end
    end
  endtask

  initial begin
    int h, s, f, h2, s2, f2, h3, s3, f3;
    rst = 1'b1; underrun_clr = 1'b0; clr4 = 1'b0;
    en1 = 1'b0; valid1 = 1'b0; data1 = 8'h00;
    en4 = 1'b0; valid4 = 1'b0; data4 = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run(1'b0, 2, h, s, f);

    // Reset state
    chk("rst_ready", ready1, 1);
    chk("rst_duty", duty1, 8'h80);
    chk("rst_pwm", pwm1, 0);
    chk("rst_ps", ps1, 0);
    chk("rst_ur", ur1, 0);

    // 1: no samples, duty 0x80 -> 128 high, empty boundary at clock 256
    en1 = 1'b1;
    run(1'b0, 256, h, s, f);
    chk("t1_highs", h, 128);
    chk("t1_starts", s, 1);
    chk("t1_first", f, 256);
    chk("t1_ur", ur1, 1);
    chk("t1_duty", duty1, 8'h80);

    // 2: push -128 -> duty 0x00, then 127 -> duty 0xFF
    underrun_clr = 1'b1; valid1 = 1'b1; data1 = 8'h80;
    run(1'b0, 1, h, s, f);
    chk("t2_ready_lo", ready1, 0);
    chk("t2_ur_clr", ur1, 0);
    underrun_clr = 1'b0; valid1 = 1'b0; data1 = 8'h55;
    run(1'b0, 255, h2, s2, f2);
    chk("t2_p1_highs", h + h2, 128);
    chk("t2_p1_first", f2, 255);
    chk("t2_duty00", duty1, 8'h00);
    chk("t2_ready_hi", ready1, 1);
    chk("t2_ur0", ur1, 0);
    valid1 = 1'b1; data1 = 8'h7F;
    run(1'b0, 1, h, s, f);
    valid1 = 1'b0;
    run(1'b0, 255, h2, s2, f2);
    chk("t2_p2_highs", h + h2, 0);
    chk("t2_p2_starts", s + s2, 1);
    chk("t2_dutyFF", duty1, 8'hFF);

    // 3: back-to-back handshake 0x10 then 0x20
    valid1 = 1'b1; data1 = 8'h10;
    run(1'b0, 1, h, s, f);
    chk("t3_ready_acc", ready1, 0);
    data1 = 8'h20;
    run(1'b0, 254, h2, s2, f2);
    chk("t3_ready_hold", ready1, 0);
    chk("t3_duty_hold", duty1, 8'hFF);
    run(1'b0, 1, h3, s3, f3);
    chk("t3_bnd_ps", s3, 1);
    chk("t3_ready_bnd", ready1, 1);
    chk("t3_duty90", duty1, 8'h90);
    chk("t3_pFF_highs", h + h2 + h3, 255);
    chk("t3_ur0", ur1, 0);
    run(1'b0, 1, h, s, f);
    chk("t3_ready_acc2", ready1, 0);
    valid1 = 1'b0;
    run(1'b0, 255, h2, s2, f2);
    chk("t3_p90_highs", h + h2, 144);
    chk("t3_dutyA0", duty1, 8'hA0);
    chk("t3_ur0b", ur1, 0);

    // 5: drop en at cnt=100 for 20 clocks
    run(1'b0, 100, h, s, f);
    chk("t5_pre_highs", h, 100);
    en1 = 1'b0;
    run(1'b0, 1, h, s, f);
    chk("t5_pwm_off", pwm1, 0);
    run(1'b0, 19, h2, s2, f2);
    chk("t5_off_highs", h + h2, 0);
    chk("t5_off_starts", s + s2, 0);
    en1 = 1'b1;
    run(1'b0, 156, h, s, f);
    chk("t5_resume_highs", h, 60);
    chk("t5_resume_first", f, 156);
    chk("t5_ur", ur1, 1);
    chk("t5_duty", duty1, 8'hA0);

    // 6: clear coinciding with an empty boundary -> set wins
    underrun_clr = 1'b1;
    run(1'b0, 1, h, s, f);
    chk("t6_clr", ur1, 0);
    underrun_clr = 1'b0;
    run(1'b0, 254, h, s, f);
    chk("t6_no_start", s, 0);
    underrun_clr = 1'b1;
    run(1'b0, 1, h, s, f);
    chk("t6_bnd_start", s, 1);
    chk("t6_set_wins", ur1, 1);
    underrun_clr = 1'b0;

    // 6: async reset mid-period with a held sample
    valid1 = 1'b1; data1 = 8'h30;
    run(1'b0, 1, h, s, f);
    valid1 = 1'b0;
    chk("t6_held", ready1, 0);
    run(1'b0, 10, h, s, f);
    chk("t6_pwm_pre", pwm1, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ready", ready1, 1);
    chk("t6_rst_duty", duty1, 8'h80);
    chk("t6_rst_pwm", pwm1, 0);
    chk("t6_rst_ur", ur1, 0);
    @(posedge clk); #1 rst = 1'b0;
    run(1'b0, 256, h, s, f);
    chk("t6_cnt0_first", f, 256);
    chk("t6_cnt0_highs", h, 128);
    chk("t6_discard_duty", duty1, 8'h80);
    chk("t6_discard_ur", ur1, 1);

    // 4: PRESCALE=4, sample 0x00 -> duty 0x80, period 1024
    en1 = 1'b0;
    valid4 = 1'b1; data4 = 8'h00; en4 = 1'b1;
    run(1'b1, 1, h, s, f);
    chk("t4_ready", ready4, 0);
    valid4 = 1'b0;
    run(1'b1, 1023, h2, s2, f2);
    chk("t4_p1_highs", h + h2, 512);
    chk("t4_p1_starts", s + s2, 1);
    chk("t4_p1_first", f2, 1023);
    chk("t4_duty", duty4, 8'h80);
    chk("t4_ur0", ur4, 0);
    run(1'b1, 1024, h, s, f);
    chk("t4_p2_highs", h, 512);
    chk("t4_p2_first", f, 1024);
    chk("t4_p2_starts", s, 1);
    chk("t4_ur1", ur4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
